// File: rtl/adc_capture_scheduler_pkg.sv
// Shared state encodings, command bytes and frame marker bytes for the ADC capture scheduler.
package adc_capture_scheduler_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RST   = 3'd1;
    localparam logic [2:0] ST_CAL   = 3'd2;
    localparam logic [2:0] ST_SAMP  = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_RST   = ST_RST,
        S_CAL   = ST_CAL,
        S_SAMP  = ST_SAMP,
        S_DRAIN = ST_DRAIN
    } state_t;

    localparam logic [7:0] CMD_START = 8'h53;
    localparam logic [7:0] CMD_ABORT = 8'h52;
    localparam logic [7:0] HDR_BYTE  = 8'hA5;
    localparam logic [7:0] TRL_BYTE  = 8'h5A;

    // Idle cycles the sender inserts after each write strobe before looking at uart_rdy.
    localparam int GUARD_CYC = 2;

    function automatic logic [7:0] trailer_byte(input logic ovf);
        return TRL_BYTE | {7'd0, ovf};
    endfunction

endpackage

// File: rtl/adc_capture_scheduler_if.sv
// UART and ADC pin bundle for the capture scheduler; master is the scheduler side.
interface adc_capture_scheduler_if #(
    parameter int NUM_bit = 6
) ();
    logic [7:0]         uart_rdata;
    logic               uart_vld;
    logic               uart_rdy;
    logic               uart_wreq;
    logic [7:0]         uart_wdata;
    logic               adc_ack;
    logic [NUM_bit-1:0] adc_dout;
    logic               adc_rstn;
    logic               adc_calib_ena;
    logic               adc_ena;
    logic               busy;
    logic               overflow;
    logic [2:0]         state_dbg;

    modport master (
        input  uart_rdata, uart_vld, uart_rdy, adc_ack, adc_dout,
        output uart_wreq, uart_wdata, adc_rstn, adc_calib_ena, adc_ena,
               busy, overflow, state_dbg
    );

    modport slave (
        output uart_rdata, uart_vld, uart_rdy, adc_ack, adc_dout,
        input  uart_wreq, uart_wdata, adc_rstn, adc_calib_ena, adc_ena,
               busy, overflow, state_dbg
    );
endinterface

// File: rtl/adc_capture_scheduler_sync_fifo.sv
// Single-clock FIFO with registered read data and a synchronous flush that overrides push/pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // Read data resets to zero because it drives uart_wdata directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         rdata <= '0;
        else if (do_pop) rdata <= mem[rd_ptr];
    end
endmodule

// File: rtl/adc_capture_scheduler.sv
// ADC run sequencer (reset, calibrate, sample, drain) with FIFO-buffered UART streaming.
// Optional frame markers (header/trailer bytes) are built when GIRAFFE_FRAME_MARKER_EN is defined.
module adc_capture_scheduler
    import adc_capture_scheduler_pkg::*;
#(
    parameter int NUM_bit         = 6,
    parameter int NUM_Sampled     = 102400,
    parameter int NUM_Calibration = 1000,
    parameter int RST_CYC         = 16,
    parameter int FIFO_DEPTH      = 64
) (
    input logic                     clk,
    input logic                     rst,
    adc_capture_scheduler_if.master bus
);
    localparam int RST_W = $clog2(RST_CYC + 1);
    localparam int CAL_W = $clog2(NUM_Calibration + 1);
    localparam int SMP_W = $clog2(NUM_Sampled + 1);
    localparam int GRD_W = $clog2(GUARD_CYC + 2);

    state_t             state;
    state_t             state_nx;
    logic [RST_W-1:0]   rst_cnt;
    logic [CAL_W-1:0]   cal_cnt;
    logic [SMP_W-1:0]   smp_cnt;
    logic [GRD_W-1:0]   guard;
    logic [NUM_bit-1:0] dout;
    logic               start_cmd, abort_cmd;
    logic               rst_last, cal_last, smp_last;
    logic               samp_ack, fifo_push, drain_done;
    logic               fifo_full, fifo_empty;
    logic [7:0]         fifo_rdata;
    logic               can_send, pop, mark_go, tx_go;
    logic               adc_rstn_q, calib_q, ena_q, wreq_q, ovf_q;

    assign dout      = bus.adc_dout;
    assign abort_cmd = bus.uart_vld && (bus.uart_rdata == CMD_ABORT);
    assign start_cmd = bus.uart_vld && (bus.uart_rdata == CMD_START) && (state == S_IDLE);
    assign rst_last  = (rst_cnt == RST_W'(RST_CYC - 1));
    assign cal_last  = bus.adc_ack && (cal_cnt == CAL_W'(NUM_Calibration - 1));
    assign smp_last  = bus.adc_ack && (smp_cnt == SMP_W'(NUM_Sampled - 1));
    assign samp_ack  = (state == S_SAMP) && bus.adc_ack && !abort_cmd;
    assign fifo_push = samp_ack && !fifo_full;
    assign can_send  = bus.uart_rdy && (guard == '0) && !abort_cmd;
    assign tx_go     = pop || mark_go;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (abort_cmd) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start_cmd)  state_nx = S_RST;
                S_RST:   if (rst_last)   state_nx = S_CAL;
                S_CAL:   if (cal_last)   state_nx = S_SAMP;
                S_SAMP:  if (smp_last)   state_nx = S_DRAIN;
                S_DRAIN: if (drain_done) state_nx = S_IDLE;
                default:                 state_nx = S_IDLE;
            endcase
        end
    end

    // Run counters saturate at their terminal value; START rearms them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_cnt <= '0;
            cal_cnt <= '0;
            smp_cnt <= '0;
        end else if (start_cmd) begin
            rst_cnt <= '0;
            cal_cnt <= '0;
            smp_cnt <= '0;
        end else if (!abort_cmd) begin
            if (state == S_RST && rst_cnt != RST_W'(RST_CYC))
                rst_cnt <= rst_cnt + 1'b1;
            if (state == S_CAL && bus.adc_ack && cal_cnt != CAL_W'(NUM_Calibration))
                cal_cnt <= cal_cnt + 1'b1;
            if (state == S_SAMP && bus.adc_ack && smp_cnt != SMP_W'(NUM_Sampled))
                smp_cnt <= smp_cnt + 1'b1;
        end
    end

    // ADC pins are registered from the next state so they change with the state itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            adc_rstn_q <= 1'b0;
            calib_q    <= 1'b0;
            ena_q      <= 1'b0;
            wreq_q     <= 1'b0;
            guard      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            adc_rstn_q <= (state_nx != S_RST);
            calib_q    <= (state_nx == S_CAL);
            ena_q      <= (state_nx == S_SAMP);
            wreq_q     <= tx_go;
            if (tx_go)              guard <= GRD_W'(GUARD_CYC + 1);
            else if (guard != '0)   guard <= guard - 1'b1;
            if (start_cmd)                  ovf_q <= 1'b0;
            else if (samp_ack && fifo_full) ovf_q <= 1'b1;
        end
    end

`ifdef GIRAFFE_FRAME_MARKER_EN
    logic       hdr_pend, trl_sent, mark_sel;
    logic [7:0] mark_q;
    logic       trl_want;

    assign trl_want   = (state == S_DRAIN) && fifo_empty && !trl_sent;
    assign mark_go    = can_send && (hdr_pend || trl_want);
    assign pop        = can_send && !fifo_empty && !mark_go;
    assign drain_done = trl_sent && bus.uart_rdy;

    // Header is queued on SAMP entry; trailer only once the FIFO has fully drained.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hdr_pend <= 1'b0;
            trl_sent <= 1'b0;
            mark_sel <= 1'b0;
            mark_q   <= 8'd0;
        end else begin
            if (start_cmd) trl_sent <= 1'b0;
            if (abort_cmd) begin
                hdr_pend <= 1'b0;
            end else if (state == S_CAL && state_nx == S_SAMP) begin
                hdr_pend <= 1'b1;
            end else if (mark_go) begin
                if (hdr_pend) hdr_pend <= 1'b0;
                else          trl_sent <= 1'b1;
            end
            if (tx_go)   mark_sel <= mark_go;
            if (mark_go) mark_q   <= hdr_pend ? HDR_BYTE : trailer_byte(ovf_q);
        end
    end

    assign bus.uart_wdata = mark_sel ? mark_q : fifo_rdata;
`else
    assign mark_go        = 1'b0;
    assign pop            = can_send && !fifo_empty;
    assign drain_done     = fifo_empty && bus.uart_rdy;
    assign bus.uart_wdata = fifo_rdata;
`endif

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (abort_cmd),
        .push  (fifo_push),
        .wdata (8'(dout)),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.uart_wreq     = wreq_q;
    assign bus.adc_rstn      = adc_rstn_q;
    assign bus.adc_calib_ena = calib_q;
    assign bus.adc_ena       = ena_q;
    assign bus.busy          = (state != S_IDLE);
    assign bus.overflow      = ovf_q;
    assign bus.state_dbg     = state;
endmodule

// File: tb/tb_adc_capture_scheduler.sv
// Randomized scoreboard bench for adc_capture_scheduler; marker bytes expected when
// GIRAFFE_FRAME_MARKER_EN is defined.
module tb_adc_capture_scheduler;
    import adc_capture_scheduler_pkg::*;

    localparam int NB = 6;
    localparam int NS = 8;
    localparam int NC = 4;
    localparam int RC = 16;
    localparam int FD = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;
    logic [7:0] exp_q[$];

    adc_capture_scheduler_if #(.NUM_bit(NB)) bus ();

    adc_capture_scheduler #(
        .NUM_bit         (NB),
        .NUM_Sampled     (NS),
        .NUM_Calibration (NC),
        .RST_CYC         (RC),
        .FIFO_DEPTH      (FD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected byte.
    always @(negedge clk) begin
        if (!rst && bus.uart_wreq) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_tx actual=0x%0h expected=none", bus.uart_wdata);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (bus.uart_wdata != e) begin
                    failures++;
                    $display("FAIL tx_byte actual=0x%0h expected=0x%0h", bus.uart_wdata, e);
                end
            end
        end
    end

    task automatic drive(input logic vld, input logic [7:0] rd, input logic ack,
                         input logic [NB-1:0] d);
        @(posedge clk); #1;
        bus.uart_vld = vld; bus.uart_rdata = rd; bus.adc_ack = ack; bus.adc_dout = d;
        @(posedge clk); #1;
        bus.uart_vld = 1'b0; bus.adc_ack = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] junk_byte();
        logic [7:0] b;
        b = 8'($urandom);
        while (b == CMD_START || b == CMD_ABORT) b = 8'($urandom);
        return b;
    endfunction

    task automatic wait_idle(input int max_cyc);
        int n = 0;
        while (bus.busy && n < max_cyc) begin
            @(posedge clk); #1;
            n++;
        end
        chk("busy_drop", int'(bus.busy), 0);
    endtask

    // START, then check the reset pulse length and walk through calibration.
    task automatic start_and_cal();
        int n = 0;
        drive(1'b1, CMD_START, 1'b0, '0);
        chk("busy_after_start", int'(bus.busy), 1);
        for (int i = 0; i < 200; i++) begin
            if (bus.adc_calib_ena) break;
            if (!bus.adc_rstn) n++;
            @(posedge clk); #1;
        end
        chk("rst_cycles", n, RC);
        chk("calib_ena", int'(bus.adc_calib_ena), 1);
        for (int i = 0; i < NC; i++) begin
            idle($urandom_range(0, 2));
            drive(1'b0, 8'd0, 1'b1, NB'($urandom));
        end
        chk("samp_entry_ena", int'(bus.adc_ena), 1);
        chk("samp_entry_calib", int'(bus.adc_calib_ena), 0);
    endtask

    task automatic run_lossless(input bit start_in_samp, input bit ramp);
        logic [NB-1:0] d;
        bus.uart_rdy = 1'b1;
        start_and_cal();
`ifdef GIRAFFE_FRAME_MARKER_EN
        exp_q.push_back(HDR_BYTE);
`endif
        for (int i = 0; i < NS; i++) begin
            idle($urandom_range(4, 6));
            if ($urandom_range(0, 1) == 1) drive(1'b1, junk_byte(), 1'b0, '0);
            if (start_in_samp && i == 3) drive(1'b1, CMD_START, 1'b0, '0);
            d = ramp ? NB'(i) : NB'($urandom);
            exp_q.push_back(8'(d));
            drive(1'b0, 8'd0, 1'b1, d);
            if (i == NS - 2) chk("samp_hold", int'(bus.adc_ena), 1);
        end
        chk("ena_drop", int'(bus.adc_ena), 0);
        chk("state_drain", int'(bus.state_dbg), int'(ST_DRAIN));
`ifdef GIRAFFE_FRAME_MARKER_EN
        exp_q.push_back(TRL_BYTE);
`endif
        wait_idle(500);
        chk("overflow_clear", int'(bus.overflow), 0);
        idle(5);
        chk("tx_all_sent", exp_q.size(), 0);
    endtask

    task automatic run_overflow();
        int n;
        logic [NB-1:0] d;
        bus.uart_rdy = 1'b0;
        start_and_cal();
`ifdef GIRAFFE_FRAME_MARKER_EN
        exp_q.push_back(HDR_BYTE);
`endif
        n = $urandom_range(FD + 2, FD + 5);
        if (n > NS) n = NS;
        for (int i = 0; i < n; i++) begin
            d = NB'($urandom);
            if (i < FD) exp_q.push_back(8'(d));
            drive(1'b0, 8'd0, 1'b1, d);
        end
        chk("overflow_set", int'(bus.overflow), 1);
        for (int i = n; i < NS; i++) drive(1'b0, 8'd0, 1'b1, NB'($urandom));
        chk("ovf_state_drain", int'(bus.state_dbg), int'(ST_DRAIN));
        idle(10);
        chk("drain_hold", int'(bus.busy), 1);
`ifdef GIRAFFE_FRAME_MARKER_EN
        exp_q.push_back(trailer_byte(1'b1));
`endif
        bus.uart_rdy = 1'b1;
        wait_idle(500);
        idle(5);
        chk("ovf_tx_all_sent", exp_q.size(), 0);
    endtask

    initial begin
        bus.uart_rdata = 8'd0; bus.uart_vld = 1'b0; bus.uart_rdy = 1'b1;
        bus.adc_ack = 1'b0;    bus.adc_dout = '0;
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_adc_rstn", int'(bus.adc_rstn), 0);
        chk("rst_wreq", int'(bus.uart_wreq), 0);
        chk("rst_wdata", int'(bus.uart_wdata), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_state", int'(bus.state_dbg), int'(ST_IDLE));
        chk("rst_overflow", int'(bus.overflow), 0);
        chk("rst_ena", int'(bus.adc_ena) + int'(bus.adc_calib_ena), 0);
        rst = 1'b0;
        idle(1);
        chk("idle_adc_rstn", int'(bus.adc_rstn), 1);

        run_lossless(1'b1, 1'b1);

        // ABORT together with the second calibration ack.
        start_and_cal_abort: begin
            drive(1'b1, CMD_START, 1'b0, '0);
            idle(RC + 2);
            chk("abort_cal_state", int'(bus.state_dbg), int'(ST_CAL));
            drive(1'b0, 8'd0, 1'b1, NB'($urandom));
            drive(1'b1, CMD_ABORT, 1'b1, NB'($urandom));
            chk("abort_cal_idle", int'(bus.state_dbg), int'(ST_IDLE));
            chk("abort_cal_calib", int'(bus.adc_calib_ena), 0);
            chk("abort_cal_busy", int'(bus.busy), 0);
            idle(20);
        end

        run_overflow();
        run_lossless(1'b0, 1'b0);

        // ABORT mid-SAMP with bytes held back: they must be flushed, never sent.
        bus.uart_rdy = 1'b0;
        start_and_cal();
        for (int i = 0; i < 3; i++) drive(1'b0, 8'd0, 1'b1, NB'($urandom));
        drive(1'b1, CMD_ABORT, 1'b0, '0);
        chk("abort_samp_idle", int'(bus.state_dbg), int'(ST_IDLE));
        chk("abort_samp_ena", int'(bus.adc_ena), 0);
        bus.uart_rdy = 1'b1;
        idle(20);

        // Asynchronous reset in the middle of SAMP.
        bus.uart_rdy = 1'b0;
        start_and_cal();
        for (int i = 0; i < 2; i++) drive(1'b0, 8'd0, 1'b1, NB'($urandom));
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("amid_rst_adc_rstn", int'(bus.adc_rstn), 0);
        chk("amid_rst_ena", int'(bus.adc_ena), 0);
        chk("amid_rst_wreq", int'(bus.uart_wreq), 0);
        chk("amid_rst_state", int'(bus.state_dbg), int'(ST_IDLE));
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        bus.uart_rdy = 1'b1;
        idle(20);

        run_lossless(1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
